// File: rtl/cpu16_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU control path.
// Contents: ALUOp codes, opcode/funct values, ALUSrcB select encodings and
// the controller state type. No ports; imported by the control modules.
package cpu16_pkg;

  // ALUOp codes; the result-select mux claims SLTI/SLL/SRA, all others go to ALU16.
  localparam logic [3:0] ALUOP_NONE = 4'b0000;
  localparam logic [3:0] ALUOP_SLTI = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_SUB  = 4'b0011;
  localparam logic [3:0] ALUOP_AND  = 4'b0100;
  localparam logic [3:0] ALUOP_OR   = 4'b0101;
  localparam logic [3:0] ALUOP_SLL  = 4'b0110;
  localparam logic [3:0] ALUOP_SRA  = 4'b0111;
  localparam logic [3:0] ALUOP_XOR  = 4'b1000;

  // Opcodes, Instruksioni[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SLTI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0011;
  localparam logic [3:0] OP_SW    = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  // R-type funct, Instruksioni[2:0]; 3'b111 is illegal
  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_XOR = 3'b100;
  localparam logic [2:0] FN_SLL = 3'b101;
  localparam logic [2:0] FN_SRA = 3'b110;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_JMP = 2'b11;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

endpackage

// File: rtl/alu_kontrolli.sv
// Combinational opcode/funct decoder producing the 4-bit ALUOp and an
// illegal-instruction flag. Shared with the single-cycle CPU.
// Ports: op_i (opcode), funct_i (R-type funct), aluop_o, illegal_o.
module alu_kontrolli
  import cpu16_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [2:0] funct_i,
  output logic [3:0] aluop_o,
  output logic       illegal_o
);

  always_comb begin
    aluop_o   = ALUOP_ADD;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADD:  aluop_o = ALUOP_ADD;
          FN_SUB:  aluop_o = ALUOP_SUB;
          FN_AND:  aluop_o = ALUOP_AND;
          FN_OR:   aluop_o = ALUOP_OR;
          FN_XOR:  aluop_o = ALUOP_XOR;
          FN_SLL:  aluop_o = ALUOP_SLL;
          FN_SRA:  aluop_o = ALUOP_SRA;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI:      aluop_o = ALUOP_ADD;
      OP_SLTI:      aluop_o = ALUOP_SLTI;
      OP_LW, OP_SW: aluop_o = ALUOP_ADD;
      OP_BEQ:       aluop_o = ALUOP_SUB;
      OP_J:         aluop_o = ALUOP_ADD;
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/kontrolli_shumeciklik.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB per instruction, plus a
// sticky HALT on illegal instructions or memory timeout.
// Ports: Clock, Reset (async, active-high), Instruksioni, Zero, MemGati in;
// memory requests, datapath enables, ALUSrcA/B, ALUOp, Gabim, NumrInstr out.
module kontrolli_shumeciklik
  import cpu16_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      Instruksioni,
  input  logic             Zero,
  input  logic             MemGati,
  output logic             MemLexo,
  output logic             MemShkruaj,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic             Gabim,
  output logic [CNT_W-1:0] NumrInstr
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       funct_q, funct_d;
  logic [3:0]       dec_op;
  logic [2:0]       dec_funct;
  logic [3:0]       dec_aluop;
  logic             dec_illegal;
  logic             tmo_hit;
  logic             retire;

  // Zero is qualified in the datapath via PCWriteCond; middle IR bits are operands.
  logic unused_inputs;
  assign unused_inputs = ^{Zero, Instruksioni[11:3]};

  // IR is fresh in DECODE; afterwards use the copy latched there.
  assign dec_op    = (state_q == StDecode) ? Instruksioni[15:12] : op_q;
  assign dec_funct = (state_q == StDecode) ? Instruksioni[2:0]   : funct_q;

  alu_kontrolli u_alu_kontrolli (
    .op_i      (dec_op),
    .funct_i   (dec_funct),
    .aluop_o   (dec_aluop),
    .illegal_o (dec_illegal)
  );

  // Last permitted wait cycle; MemGati in this cycle still completes normally.
  assign tmo_hit = (tmo_q == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
      tmo_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    funct_d = funct_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (MemGati)      state_d = StDecode;
        else if (tmo_hit) state_d = StHalt;
        else              tmo_d   = tmo_q + TW'(1);
      end
      StDecode: begin
        op_d    = Instruksioni[15:12];
        funct_d = Instruksioni[2:0];
        state_d = dec_illegal ? StHalt : StExec;
      end
      StExec: begin
        unique case (op_q)
          OP_BEQ, OP_J: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
          OP_LW, OP_SW: state_d = StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        if (MemGati) begin
          if (op_q == OP_LW) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = StHalt;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
    // Every entry into a waiting state starts a fresh timeout window.
    if (state_d != state_q) tmo_d = '0;
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign NumrInstr = cnt_q;

  // Reset gates the decode so requests drop immediately, not at the next edge.
  always_comb begin
    MemLexo     = 1'b0;
    MemShkruaj  = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_NONE;
    Gabim       = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        StFetch: begin
          MemLexo = 1'b1;
          ALUSrcB = SRCB_TWO;
          ALUOp   = ALUOP_ADD;
          IRWrite = MemGati;
          PCWrite = MemGati;
        end
        StDecode: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        StExec: begin
          ALUOp = dec_aluop;
          unique case (op_q)
            OP_RTYPE: ALUSrcA = 1'b1;
            OP_BEQ: begin
              ALUSrcA     = 1'b1;
              PCWriteCond = 1'b1;
            end
            OP_J: begin
              ALUSrcB = SRCB_JMP;
              PCWrite = 1'b1;
            end
            default: begin
              ALUSrcA = 1'b1;
              ALUSrcB = SRCB_IMM;
            end
          endcase
        end
        StMem: begin
          MemLexo    = (op_q == OP_LW);
          MemShkruaj = (op_q == OP_SW);
        end
        StWb: begin
          RegWrite = 1'b1;
          RegDst   = (op_q == OP_RTYPE);
          MemToReg = (op_q == OP_LW);
        end
        StHalt:  Gabim = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kontrolli_shumeciklik.sv
// Self-checking bench for kontrolli_shumeciklik: directed vector table,
// random instructions against a per-instruction cost/effect model, and
// hand-written sequences for halts, timeouts and reset mid-request.
module tb_kontrolli_shumeciklik;
  import cpu16_pkg::*;

  localparam int unsigned TO = 15;
  localparam int unsigned CW = 4;  // narrow counter so wrap-around is exercised

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [15:0]   Instruksioni = '0;
  logic          Zero = 1'b0;
  logic          MemGati = 1'b0;
  logic          MemLexo, MemShkruaj, IRWrite, PCWrite, PCWriteCond;
  logic          RegWrite, RegDst, MemToReg, ALUSrcA, Gabim;
  logic [1:0]    ALUSrcB;
  logic [3:0]    ALUOp;
  logic [CW-1:0] NumrInstr;

  always #5 Clock = ~Clock;

  kontrolli_shumeciklik #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Instruksioni(Instruksioni), .Zero(Zero),
    .MemGati(MemGati), .MemLexo(MemLexo), .MemShkruaj(MemShkruaj), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Gabim(Gabim), .NumrInstr(NumrInstr)
  );

  typedef struct {
    logic [15:0] instr; logic zero; int fw; int mw;
    int cycles; logic [3:0] aluop; logic [1:0] srcb; int rw; logic rd; logic m2r;
    int ml; int ms; int pcw; int pcwc;
  } vec_t;

  typedef struct {
    int cycles; int ml; int ms; int rw; int pcw; int pcwc; int irw;
    logic [3:0] aluop; logic [1:0] srcb; logic rd; logic m2r; logic halted;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {MemLexo, MemShkruaj, IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemToReg,
            ALUSrcA, ALUSrcB, ALUOp, Gabim};
  endfunction

  function automatic vec_t mk(logic [15:0] instr, logic zero, int fw, int mw, int cycles,
                              logic [3:0] aluop, logic [1:0] srcb, int rw, logic rd,
                              logic m2r, int ml, int ms, int pcw, int pcwc);
    vec_t v;
    v.instr = instr; v.zero = zero; v.fw = fw; v.mw = mw; v.cycles = cycles;
    v.aluop = aluop; v.srcb = srcb; v.rw = rw; v.rd = rd; v.m2r = m2r;
    v.ml = ml; v.ms = ms; v.pcw = pcw; v.pcwc = pcwc;
    return v;
  endfunction

  // Whole-instruction effect derived from the ISA rules: cycle cost, request
  // cycles, enables asserted and the EXEC-phase ALU setting.
  function automatic vec_t model(logic [15:0] instr, logic zero, int fw, int mw);
    logic [3:0] op;
    logic [2:0] f;
    logic [3:0] aop;
    logic [1:0] sb;
    bit mem, wb;
    op  = instr[15:12];
    f   = instr[2:0];
    mem = (op == 4'd3) || (op == 4'd4);
    wb  = (op <= 4'd3);
    aop = 4'b0010;
    sb  = 2'b10;
    case (op)
      4'd0: begin
        sb = 2'b00;
        case (f)
          3'd1: aop = 4'b0011;
          3'd2: aop = 4'b0100;
          3'd3: aop = 4'b0101;
          3'd4: aop = 4'b1000;
          3'd5: aop = 4'b0110;
          3'd6: aop = 4'b0111;
          default: aop = 4'b0010;
        endcase
      end
      4'd2: aop = 4'b0001;
      4'd5: begin aop = 4'b0011; sb = 2'b00; end
      4'd6: sb = 2'b11;
      default: ;
    endcase
    return mk(instr, zero, fw, mw,
              (fw + 1) + 2 + (mem ? mw + 1 : 0) + (wb ? 1 : 0),
              aop, sb, wb ? 1 : 0, op == 4'd0, op == 4'd3,
              (fw + 1) + ((op == 4'd3) ? mw + 1 : 0), (op == 4'd4) ? mw + 1 : 0,
              1 + ((op == 4'd6) ? 1 : 0), (op == 4'd5) ? 1 : 0);
  endfunction

  // Starts in FETCH just after an edge. Each memory request is answered after
  // fw (first request) or mw (second) idle cycles; ends on retire or error.
  task automatic run_instr(input logic [15:0] instr, input logic zero, input int fw,
                           input int mw, output obs_t o);
    logic [CW-1:0] start;
    int tgt[2];
    int ridx, wcnt, c_ir;
    bit done;
    o.cycles = 0; o.ml = 0; o.ms = 0; o.rw = 0; o.pcw = 0; o.pcwc = 0; o.irw = 0;
    o.aluop = 'x; o.srcb = 'x; o.rd = 1'b0; o.m2r = 1'b0; o.halted = 1'b0;
    tgt[0] = fw; tgt[1] = mw;
    ridx = 0; wcnt = 0; c_ir = -10; done = 1'b0;
    start = NumrInstr;
    Instruksioni = instr;
    Zero = zero;
    for (int c = 0; c < 64 && !done; c++) begin
      if ((MemLexo || MemShkruaj) && ridx < 2) MemGati = (wcnt == tgt[ridx]);
      else MemGati = 1'b0;
      @(negedge Clock);
      o.cycles++;
      if (MemLexo)     o.ml++;
      if (MemShkruaj)  o.ms++;
      if (PCWrite)     o.pcw++;
      if (PCWriteCond) o.pcwc++;
      if (IRWrite) begin o.irw++; c_ir = c; end
      if (c == c_ir + 2) begin o.aluop = ALUOp; o.srcb = ALUSrcB; end
      if (RegWrite) begin o.rw++; o.rd = RegDst; o.m2r = MemToReg; end
      if (MemGati) begin ridx++; wcnt = 0; end
      else if (MemLexo || MemShkruaj) wcnt++;
      @(posedge Clock); #1;
      if (NumrInstr != start || Gabim) done = 1'b1;
    end
    MemGati = 1'b0;
    o.halted = Gabim;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL run_instr %h: no retire or error within 64 cycles", instr);
    end
  endtask

  task automatic compare_vec(input string tag, input vec_t v, input obs_t o);
    check({tag, " cycles"}, o.cycles, v.cycles);
    check({tag, " exec ALUOp"}, o.aluop, v.aluop);
    check({tag, " exec ALUSrcB"}, o.srcb, v.srcb);
    check({tag, " RegWrite cycles"}, o.rw, v.rw);
    check({tag, " RegDst"}, o.rd, v.rd);
    check({tag, " MemToReg"}, o.m2r, v.m2r);
    check({tag, " MemLexo cycles"}, o.ml, v.ml);
    check({tag, " MemShkruaj cycles"}, o.ms, v.ms);
    check({tag, " PCWrite cycles"}, o.pcw, v.pcw);
    check({tag, " PCWriteCond cycles"}, o.pcwc, v.pcwc);
    check({tag, " IRWrite cycles"}, o.irw, 1);
    check({tag, " Gabim"}, o.halted, 0);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check({tag, " NumrInstr"}, NumrInstr, exp_cnt);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    MemGati = 1'b0;
    @(posedge Clock); #1;
    check({tag, " outputs in reset"}, outs(), 16'h0000);
    check({tag, " NumrInstr in reset"}, NumrInstr, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_cnt = 0;
    #1;
    check({tag, " FETCH after reset"}, outs(), 16'h8024);  // MemLexo, SrcB=01, ADD
  endtask

  task automatic check_halt(input string tag);
    for (int i = 0; i < 6; i++) begin
      MemGati = i[0];
      @(negedge Clock);
      check($sformatf("%s halted cycle %0d", tag, i), outs(), 16'h0001);
      @(posedge Clock); #1;
    end
    MemGati = 1'b0;
  endtask

  initial begin
    obs_t o;
    vec_t v;
    logic [15:0] ins;
    //                instr    z  fw  mw cyc aluop  srcb   rw rd m2r ml ms pcw pcwc
    tbl[0]  = mk(16'h0128, 0,  0, 0,  4, 4'b0010, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[1]  = mk(16'h0F01, 0,  0, 0,  4, 4'b0011, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[2]  = mk(16'h0002, 0,  0, 0,  4, 4'b0100, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[3]  = mk(16'h0A53, 0,  1, 0,  5, 4'b0101, 2'b00, 1, 1, 0,  2, 0, 1, 0);
    tbl[4]  = mk(16'h0004, 0,  0, 0,  4, 4'b1000, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[5]  = mk(16'h00F5, 0,  0, 0,  4, 4'b0110, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[6]  = mk(16'h0326, 0,  0, 0,  4, 4'b0111, 2'b00, 1, 1, 0,  1, 0, 1, 0);
    tbl[7]  = mk(16'h1234, 0,  0, 0,  4, 4'b0010, 2'b10, 1, 0, 0,  1, 0, 1, 0);
    tbl[8]  = mk(16'h2345, 0,  0, 0,  4, 4'b0001, 2'b10, 1, 0, 0,  1, 0, 1, 0);
    tbl[9]  = mk(16'h3456, 0,  0, 3,  8, 4'b0010, 2'b10, 1, 0, 1,  5, 0, 1, 0);
    tbl[10] = mk(16'h4567, 0,  1, 2,  7, 4'b0010, 2'b10, 0, 0, 0,  2, 3, 1, 0);
    tbl[11] = mk(16'h5678, 1,  0, 0,  3, 4'b0011, 2'b00, 0, 0, 0,  1, 0, 1, 1);
    tbl[12] = mk(16'h6789, 0,  2, 0,  5, 4'b0010, 2'b11, 0, 0, 0,  3, 0, 2, 0);
    tbl[13] = mk(16'h0010, 0, 14, 0, 18, 4'b0010, 2'b00, 1, 1, 0, 15, 0, 1, 0);
    tbl[14] = mk(16'h3000, 0,  0, 14, 19, 4'b0010, 2'b10, 1, 0, 1, 16, 0, 1, 0);
    tbl[15] = mk(16'h5000, 0,  0, 0,  3, 4'b0011, 2'b00, 0, 0, 0,  1, 0, 1, 1);

    do_reset("init");
    check("init Gabim", Gabim, 0);

    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].instr, tbl[i].zero, tbl[i].fw, tbl[i].mw, o);
      compare_vec($sformatf("vec%0d", i), tbl[i], o);
    end

    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 6));
      if (ins[15:12] == 4'd0) ins[2:0] = 3'($urandom_range(0, 6));
      v = model(ins, 1'($urandom), int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
      run_instr(v.instr, v.zero, v.fw, v.mw, o);
      compare_vec($sformatf("rnd%0d", i), v, o);
    end

    // Illegal opcode
    do_reset("illop");
    run_instr(16'hA000, 1'b0, 0, 0, o);
    check("illop Gabim", o.halted, 1);
    check("illop cycles", o.cycles, 2);
    check_halt("illop");

    // Illegal funct
    do_reset("illfn");
    run_instr(16'h0007, 1'b0, 0, 0, o);
    check("illfn Gabim", o.halted, 1);
    check("illfn cycles", o.cycles, 2);
    check_halt("illfn");

    // FETCH timeout: MemGati never arrives
    do_reset("ftmo");
    run_instr(16'h0128, 1'b0, 99, 0, o);
    check("ftmo Gabim", o.halted, 1);
    check("ftmo MemLexo cycles", o.ml, TO);
    check_halt("ftmo");

    // MEM timeout on LW
    do_reset("mtmo");
    run_instr(16'h3000, 1'b0, 0, 99, o);
    check("mtmo Gabim", o.halted, 1);
    check("mtmo cycles", o.cycles, 3 + TO);
    check("mtmo MemLexo cycles", o.ml, 1 + TO);
    check_halt("mtmo");

    // Reset while an LW request is pending in MEM
    do_reset("rmem");
    run_instr(tbl[0].instr, 1'b0, 0, 0, o);
    compare_vec("rmem pre", tbl[0], o);
    Instruksioni = 16'h3000;
    MemGati = 1'b1;
    @(posedge Clock); #1;
    MemGati = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    check("rmem MemLexo in MEM", MemLexo, 1);
    #2 Reset = 1'b1;
    #1;
    check("rmem outputs drop async", outs(), 16'h0000);
    check("rmem NumrInstr cleared", NumrInstr, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_cnt = 0;
    #1;
    check("rmem FETCH after reset", outs(), 16'h8024);
    run_instr(tbl[9].instr, 1'b0, tbl[9].fw, tbl[9].mw, o);
    compare_vec("rmem post", tbl[9], o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
